expr_eval_sched: RTL and testbench
==================================

Name: expr_eval_sched

Overview:
- Round-robin scheduler that shares one combinational expression-evaluation unit between NREQ requesters.
- Each requester submits a packed operand bundle (a0..a5, b0..b5). The scheduler drives the bundle onto the shared unit, waits EVAL_LAT cycles for settling, captures the 90-bit result and returns it with the requester id.
- Sits between stimulus/regression drivers and the expression datapath; one transaction outstanding at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OPW, 60, operand bundle width: a0..a5 then b0..b5 packed MSB-first, 4+5+6+4+5+6 bits each half.
- RESW, 90, result width from the expression unit.
- EVAL_LAT, 1, extra settle cycles before capture (0..7).
- IDW, 2, id width; equals clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept strobe; one-hot or zero.
- req_ops  in  NREQ*OPW  operand bundles; requester i occupies bits [i*OPW +: OPW].
- exp_ops  out  OPW  operands driven to the shared expression unit.
- exp_y  in  RESW  result from the shared expression unit.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  RESW  captured result.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: state IDLE; last_grant=NREQ-1, so requester 0 has first priority; exp_ops=0; rsp_valid=0; rsp_data=0; rsp_id=0; counter=0; busy=0. req_ready is 0 during reset.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Grant goes to the first asserted req_valid, searching circularly from last_grant+1.
  - req_ready[g]=1 combinationally for that index only. The handshake completes in the same cycle.
  - On handshake: op_reg<=req_ops[g], id_reg<=g, last_grant<=g, counter<=EVAL_LAT, next state EVAL.
  - No req_valid asserted: stay in IDLE; all req_ready=0.
- EVAL:
  - exp_ops=op_reg, a registered output that is stable from the cycle after acceptance.
  - counter!=0: decrement.
  - counter==0: rsp_data<=exp_y, rsp_id<=id_reg, rsp_valid<=1, next state RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id held stable until rsp_valid&&rsp_ready.
  - On handshake: rsp_valid<=0, next state IDLE.
  - exp_ops keeps its last value.
- Latency: acceptance at edge T → rsp_valid high after edge T+1+EVAL_LAT. With EVAL_LAT=0, rsp_valid is high 2 cycles after the request cycle.
- Throughput: one transaction per 3+EVAL_LAT cycles minimum. The IDLE cycle is mandatory, with no back-to-back bypass.
- req_ready is 0 in EVAL and RESP; requests stay pending, and requesters must hold req_valid and req_ops until accepted.
- Deasserting req_valid before acceptance is legal; that requester is simply skipped.
- Fairness: a continuously asserted requester is granted within NREQ transactions.
- last_grant wraps from NREQ-1 to 0.
- Reset mid-operation (EVAL or RESP) aborts the transaction: no response is produced, and all reset values apply on the next cycle.
- exp_y is only sampled in the final EVAL cycle; its value at any other time is ignored.

Optional Feature:
- Macro: EXPR_SCHED_SIG_EN.
- Defined:
  - Adds input sig_clr (1 bit) and output sig (32 bits).
  - On each rsp handshake: sig<={sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ fold, where fold is the XOR of rsp_data split into 32-bit chunks, upper chunk zero-padded.
  - sig_clr=1 sets sig to 0 and takes priority over an update in the same cycle.
  - sig resets to 0.
- Undefined: sig and sig_clr ports are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, busy=0, exp_ops=0. After release, the first grant goes to requester 0.
2. Single request, EVAL_LAT=1: req_valid=4'b0100, req_ops[2]=60'h0123456789ABCDE; bench drives exp_y=f(exp_ops).
   - Response: req_ready=4'b0100 for exactly one cycle; exp_ops=0123456789ABCDE from the next cycle.
   - rsp_valid rises 2 cycles after acceptance, with rsp_id=2 and rsp_data=f(0123456789ABCDE).
3. Round-robin: all four req_valid held at 1 and rsp_ready=1 → grant order 0,1,2,3,0,1. Then drop req_valid[1] → order continues 2,3,0,2.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP while exp_y changes → rsp_data and rsp_id stable, req_ready=0. The response completes on the first cycle rsp_ready=1.
5. Reset mid-EVAL with EVAL_LAT=7: assert rst_n=0 at counter=3 → no rsp_valid is ever produced for that request; busy=0 and last_grant is restored so requester 0 wins next.
6. EXPR_SCHED_SIG_EN: three responses with rsp_data=90'h1, 90'h2, 90'h0 → sig matches the reference polynomial model. Pulsing sig_clr during a handshake cycle leaves sig=0.

Source files
------------

// File: rtl/expr_eval_sched_if.sv
// Request/response and shared-datapath signal bundle for expr_eval_sched.
interface expr_eval_sched_if #(
  parameter int NREQ = 4,
  parameter int OPW  = 60,
  parameter int RESW = 90,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_ops;
  logic [OPW-1:0]      exp_ops;
  logic [RESW-1:0]     exp_y;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [RESW-1:0]     rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  modport master (
    output req_valid, req_ops, exp_y, rsp_ready,
    input  req_ready, exp_ops, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_ops, exp_y, rsp_ready,
    output req_ready, exp_ops, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/expr_eval_sched.sv
// Round-robin scheduler sharing one combinational expression unit among NREQ requesters.
// Optional macro EXPR_SCHED_SIG_EN adds a 32-bit response signature (sig, sig_clr).
module expr_eval_sched #(
  parameter int NREQ     = 4,
  parameter int OPW      = 60,
  parameter int RESW     = 90,
  parameter int EVAL_LAT = 1,
  parameter int IDW      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef EXPR_SCHED_SIG_EN
  input  logic             sig_clr,
  output logic [31:0]      sig,
`endif
  expr_eval_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           gnt_found;
  logic [2:0]     counter;
  logic [OPW-1:0] ops_arr [NREQ];
  logic           rsp_hs;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      ops_arr[i] = bus.req_ops[i*OPW +: OPW];
    end
  end

  // Circular search starting one past the previous grant; the first hit wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_grant) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign bus.req_ready = (rst_n && state == IDLE && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;
  assign bus.busy      = (state != IDLE);
  assign rsp_hs        = (state == RESP) && bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= IDW'(NREQ - 1);
      id_reg        <= '0;
      counter       <= '0;
      bus.exp_ops   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_found) begin
            bus.exp_ops <= ops_arr[gnt_idx];
            id_reg      <= gnt_idx;
            last_grant  <= gnt_idx;
            counter     <= 3'(EVAL_LAT);
            state       <= EVAL;
          end
        end
        EVAL: begin
          if (counter != 3'd0) begin
            counter <= counter - 3'd1;
          end else begin
            bus.rsp_data  <= bus.exp_y;
            bus.rsp_id    <= id_reg;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXPR_SCHED_SIG_EN
  localparam int NCH = (RESW + 31) / 32;

  logic [NCH*32-1:0] rsp_pad;
  logic [31:0]       fold;

  always_comb begin
    rsp_pad             = '0;
    rsp_pad[RESW-1:0]   = bus.rsp_data;
    fold                = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      fold = fold ^ rsp_pad[c*32 +: 32];
    end
  end

  // Clear outranks an update landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || sig_clr) begin
      sig <= '0;
    end else if (rsp_hs) begin
      sig <= {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold;
    end
  end
`endif

endmodule

// File: tb/tb_expr_eval_sched.sv
// Scoreboard bench for expr_eval_sched: EVAL_LAT=1 and EVAL_LAT=7 instances.
`timescale 1ns/1ps
module tb_expr_eval_sched;
  localparam int NREQ = 4;
  localparam int OPW  = 60;
  localparam int RESW = 90;
  localparam int IDW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  expr_eval_sched_if #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .IDW(IDW)) bus1 ();
  expr_eval_sched_if #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .IDW(IDW)) bus7 ();

`ifdef EXPR_SCHED_SIG_EN
  logic        sig_clr1 = 1'b0;
  logic        sig_clr7 = 1'b0;
  logic [31:0] sig1, sig7;
`endif

  expr_eval_sched #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .EVAL_LAT(1), .IDW(IDW)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef EXPR_SCHED_SIG_EN
    .sig_clr(sig_clr1), .sig(sig1),
`endif
    .bus(bus1)
  );

  expr_eval_sched #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .EVAL_LAT(7), .IDW(IDW)) dut7 (
    .clk(clk), .rst_n(rst_n),
`ifdef EXPR_SCHED_SIG_EN
    .sig_clr(sig_clr7), .sig(sig7),
`endif
    .bus(bus7)
  );

  typedef struct {
    logic [1:0]  id;
    logic [89:0] data;
  } exp_t;

  exp_t        sb [$];
  int          total = 0;
  int          bad   = 0;
  logic [59:0] ops [4];
  logic [89:0] noise;
  logic        force_en;
  logic [89:0] force_val;

  function automatic logic [89:0] f(input logic [59:0] x);
    return {x[29:0], x} ^ 90'h2_AAAA_5555_F0F0_3C3C_9696;
  endfunction

  function automatic logic [31:0] sig_next(input logic [31:0] s, input logic [89:0] d);
    logic [95:0] p;
    p = {6'b0, d};
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ p[31:0] ^ p[63:32] ^ p[95:64];
  endfunction

  always_comb begin
    bus1.req_ops = {ops[3], ops[2], ops[1], ops[0]};
    bus7.req_ops = {ops[3], ops[2], ops[1], ops[0]};
    bus1.exp_y   = force_en ? force_val : (f(bus1.exp_ops) ^ noise);
    bus7.exp_y   = f(bus7.exp_ops);
  end

  task automatic apply_reset();
    bus1.req_valid = '0;
    bus7.req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one full transaction on bus1 with rsp_ready=1; returns at the negedge after the handshake.
  task automatic txn1(input logic [3:0] mask, input logic clr, output logic [3:0] gnt,
                      output logic [1:0] gid, output logic [89:0] gdata, output bit ok);
    int n;
    ok = 1'b0; gnt = '0; gid = '0; gdata = '0;
    bus1.req_valid = mask;
    bus1.rsp_ready = 1'b1;
    #1;
    n = 0;
    while (bus1.req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (bus1.req_ready == '0) begin
      bus1.req_valid = '0;
      return;
    end
    gnt = bus1.req_ready;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus1.rsp_valid && n < 20);
    if (!bus1.rsp_valid) begin
      bus1.req_valid = '0;
      return;
    end
    gid   = bus1.rsp_id;
    gdata = bus1.rsp_data;
`ifdef EXPR_SCHED_SIG_EN
    sig_clr1 = clr;
`endif
    @(negedge clk);
`ifdef EXPR_SCHED_SIG_EN
    sig_clr1 = 1'b0;
`endif
    bus1.req_valid = '0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.req_valid = 4'hF;
    bus7.req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++; if (bus1.req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready cyc=%0d got=%b want=0000", c, bus1.req_ready); end
      total++; if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid cyc=%0d got=%b want=0", c, bus1.rsp_valid); end
      total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=0", c, bus1.busy); end
      total++; if (bus1.exp_ops !== 60'h0) begin bad++; $display("FAIL reset_exp_ops cyc=%0d got=%h want=0", c, bus1.exp_ops); end
      total++; if (bus7.req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready7 cyc=%0d got=%b want=0000", c, bus7.req_ready); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus1.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b want=0001", bus1.req_ready); end
    total++; if (bus7.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant7 got=%b want=0001", bus7.req_ready); end
    bus1.req_valid = '0;
    bus7.req_valid = '0;
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk);
    ops[2] = 60'h0123456789ABCDE;
    bus1.rsp_ready = 1'b0;
    bus1.req_valid = 4'b0100;
    #1;
    total++; if (bus1.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", bus1.req_ready); end
    sb.push_back('{id: 2'd2, data: f(60'h0123456789ABCDE)});
    @(negedge clk);
    total++; if (bus1.req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_once got=%b want=0000", bus1.req_ready); end
    total++; if (bus1.exp_ops !== 60'h0123456789ABCDE) begin bad++; $display("FAIL single_exp_ops got=%h want=0123456789abcde", bus1.exp_ops); end
    total++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus1.busy); end
    bus1.req_valid = '0;
    @(negedge clk);
    total++; if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp got=%b want=0", bus1.rsp_valid); end
    @(negedge clk);
    total++; if (bus1.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%b want=1", bus1.rsp_valid); end
    e = sb.pop_front();
    total++; if (bus1.rsp_id !== e.id) begin bad++; $display("FAIL single_rsp_id got=%0d want=%0d", bus1.rsp_id, e.id); end
    total++; if (bus1.rsp_data !== e.data) begin bad++; $display("FAIL single_rsp_data got=%h want=%h", bus1.rsp_data, e.data); end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_drop got=%b want=0", bus1.rsp_valid); end
    total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", bus1.busy); end
    bus1.rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int          order [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
    logic [3:0]  gnt, expg;
    logic [1:0]  gid;
    logic [89:0] gdata;
    bit          ok;
    exp_t        e;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      expg = 4'b0001 << order[k];
      sb.push_back('{id: 2'(order[k]), data: f(ops[order[k]])});
      txn1((k < 6) ? 4'hF : 4'hD, 1'b0, gnt, gid, gdata, ok);
      e = sb.pop_front();
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rr_timeout step=%0d", k); end
      total++; if (gnt !== expg) begin bad++; $display("FAIL rr_grant step=%0d got=%b want=%b", k, gnt, expg); end
      total++; if (gid !== e.id) begin bad++; $display("FAIL rr_rsp_id step=%0d got=%0d want=%0d", k, gid, e.id); end
      total++; if (gdata !== e.data) begin bad++; $display("FAIL rr_rsp_data step=%0d got=%h want=%h", k, gdata, e.data); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    ops[3] = 60'h13579BDF2468ACE;
    bus1.rsp_ready = 1'b0;
    bus1.req_valid = 4'b1000;
    sb.push_back('{id: 2'd3, data: f(60'h13579BDF2468ACE)});
    #1;
    n = 0;
    while (bus1.req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    total++; if (bus1.req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant got=%b want=1000", bus1.req_ready); end
    n = 0;
    do begin @(negedge clk); n++; end while (!bus1.rsp_valid && n < 20);
    bus1.req_valid = '0;
    total++; if (bus1.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_timeout got=%b want=1", bus1.rsp_valid); end
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      noise = {26'($urandom()), $urandom(), $urandom()} | 90'h1;
      bus1.req_valid = 4'hF;
      #1;
      total++; if (bus1.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", c, bus1.rsp_valid); end
      total++; if (bus1.rsp_data !== e.data) begin bad++; $display("FAIL bp_hold_data cyc=%0d got=%h want=%h", c, bus1.rsp_data, e.data); end
      total++; if (bus1.rsp_id !== e.id) begin bad++; $display("FAIL bp_hold_id cyc=%0d got=%0d want=%0d", c, bus1.rsp_id, e.id); end
      total++; if (bus1.req_ready !== 4'h0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b want=0000", c, bus1.req_ready); end
      @(negedge clk);
    end
    bus1.req_valid = '0;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", bus1.rsp_valid); end
    bus1.rsp_ready = 1'b0;
    noise = '0;
  endtask

  task automatic test_reset_mid_eval();
    exp_t e;
    int   n;
    int   seen;
    bus7.rsp_ready = 1'b1;
    bus7.req_valid = 4'b0010;
    #1;
    n = 0;
    while (bus7.req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    total++; if (bus7.req_ready !== 4'b0010) begin bad++; $display("FAIL mid_grant got=%b want=0010", bus7.req_ready); end
    @(negedge clk);
    bus7.req_valid = '0;
    total++; if (bus7.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", bus7.busy); end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus7.rsp_valid) seen++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_rsp_before got=%0d want=0", seen); end
    total++; if (bus7.busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", bus7.busy); end
    total++; if (bus7.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_rsp got=%b want=0", bus7.rsp_valid); end
    total++; if (bus7.exp_ops !== 60'h0) begin bad++; $display("FAIL mid_reset_exp_ops got=%h want=0", bus7.exp_ops); end
    rst_n = 1'b1;
    bus7.req_valid = 4'hF;
    #1;
    total++; if (bus7.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_restart_grant got=%b want=0001", bus7.req_ready); end
    bus7.req_valid = 4'b0001;
    sb.push_back('{id: 2'd0, data: f(ops[0])});
    n = 0;
    seen = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) bus7.req_valid = '0;
      if (bus7.rsp_valid && seen == 0) begin
        seen = k;
        e = sb.pop_front();
        total++; if (bus7.rsp_id !== e.id) begin bad++; $display("FAIL lat7_rsp_id got=%0d want=%0d", bus7.rsp_id, e.id); end
        total++; if (bus7.rsp_data !== e.data) begin bad++; $display("FAIL lat7_rsp_data got=%h want=%h", bus7.rsp_data, e.data); end
      end
    end
    total++; if (seen !== 9) begin bad++; $display("FAIL lat7_latency got=%0d want=9", seen); end
    bus7.rsp_ready = 1'b0;
  endtask

`ifdef EXPR_SCHED_SIG_EN
  task automatic test_sig();
    logic [89:0] vals [3] = '{90'h1, 90'h2, 90'h0};
    logic [31:0] m;
    logic [3:0]  gnt;
    logic [1:0]  gid;
    logic [89:0] gdata;
    bit          ok;
    exp_t        e;
    apply_reset();
    m = '0;
    force_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      force_val = vals[k];
      sb.push_back('{id: 2'd0, data: vals[k]});
      txn1(4'b0001, 1'b0, gnt, gid, gdata, ok);
      e = sb.pop_front();
      m = sig_next(m, e.data);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL sig_timeout step=%0d", k); end
      total++; if (gdata !== e.data) begin bad++; $display("FAIL sig_rsp_data step=%0d got=%h want=%h", k, gdata, e.data); end
      total++; if (sig1 !== m) begin bad++; $display("FAIL sig_value step=%0d got=%h want=%h", k, sig1, m); end
    end
    force_val = 90'h3;
    txn1(4'b0001, 1'b1, gnt, gid, gdata, ok);
    total++; if (sig1 !== 32'h0) begin bad++; $display("FAIL sig_clr got=%h want=0", sig1); end
    force_en = 1'b0;
  endtask
`endif

  initial begin
    ops[0] = 60'hFEDCBA987654321;
    ops[1] = 60'h0F0F0F0F0F0F0F0;
    ops[2] = 60'h0123456789ABCDE;
    ops[3] = 60'h5A5A5A5A5A5A5A5;
    noise     = '0;
    force_en  = 1'b0;
    force_val = '0;
    bus1.req_valid = '0;
    bus1.rsp_ready = 1'b0;
    bus7.req_valid = '0;
    bus7.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_eval();
`ifdef EXPR_SCHED_SIG_EN
    test_sig();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
